// File: rtl/slv_rst_ctrl.sv
// slv_rst_ctrl: fences, drains and resets a guarded AXI slave link on request.
// Ports: clk_i/rst_i (sync active-high), rst_req_i (level reset request),
//        aw_*/ar_* address gates (guard side _i/_o, slave side _o/_i),
//        b_*/r_* observed response handshakes, slv_rst_o slave reset,
//        busy_o (not IDLE), timeout_o/underflow_o sticky flags, clr_i clears them.
//        irq_o (only with SLV_RST_CTRL_IRQ_EN) pulses once after RELEASE.
module slv_rst_ctrl #(
    parameter int MaxOutstanding = 8,
    parameter int CntWidth       = 10,
    parameter int DrainTimeout   = 512,
    parameter int RstCycles      = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rst_req_i,
    input  logic aw_valid_i,
    output logic aw_ready_o,
    output logic aw_valid_o,
    input  logic aw_ready_i,
    input  logic ar_valid_i,
    output logic ar_ready_o,
    output logic ar_valid_o,
    input  logic ar_ready_i,
    input  logic b_valid_i,
    input  logic b_ready_i,
    input  logic r_valid_i,
    input  logic r_ready_i,
    input  logic r_last_i,
    output logic slv_rst_o,
    output logic busy_o,
    output logic timeout_o,
    output logic underflow_o,
    input  logic clr_i
`ifdef SLV_RST_CTRL_IRQ_EN
    ,
    output logic irq_o
`endif
);
    localparam int OW = $clog2(MaxOutstanding + 1);
    typedef enum logic [1:0] {IDLE, FENCE, RESET, RELEASE} state_e;
    state_e state_q, state_d;
    logic [OW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [CntWidth-1:0] timer_q, timer_d;
    logic aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;
    logic pending_q, pending_d, timeout_q, timeout_d, underflow_q, underflow_d;
    logic in_rst, aw_pass, ar_pass, aw_hs, ar_hs, b_hs, r_done, to_set;
    assign in_rst = state_q == RESET;
    // A held channel stays transparent while fenced so an issued valid is never withdrawn.
    assign aw_pass = (state_q == IDLE) ? (wr_cnt_q < OW'(MaxOutstanding)) : (aw_hold_q & ~in_rst);
    assign ar_pass = (state_q == IDLE) ? (rd_cnt_q < OW'(MaxOutstanding)) : (ar_hold_q & ~in_rst);
    assign aw_valid_o = aw_valid_i & aw_pass;
    assign aw_ready_o = aw_ready_i & aw_pass;
    assign ar_valid_o = ar_valid_i & ar_pass;
    assign ar_ready_o = ar_ready_i & ar_pass;
    assign aw_hs = aw_valid_o & aw_ready_i;
    assign ar_hs = ar_valid_o & ar_ready_i;
    // Responses arriving while the slave is held in reset are ignored.
    assign b_hs = b_valid_i & b_ready_i & ~in_rst;
    assign r_done = r_valid_i & r_ready_i & r_last_i & ~in_rst;
    assign slv_rst_o = in_rst;
    assign busy_o = state_q != IDLE;
    assign timeout_o = timeout_q;
    assign underflow_o = underflow_q;
    always_comb begin
        wr_cnt_d = in_rst ? '0 : (aw_hs & ~b_hs) ? wr_cnt_q + 1'b1
                 : (b_hs & ~aw_hs & wr_cnt_q != '0) ? wr_cnt_q - 1'b1 : wr_cnt_q;
        rd_cnt_d = in_rst ? '0 : (ar_hs & ~r_done) ? rd_cnt_q + 1'b1
                 : (r_done & ~ar_hs & rd_cnt_q != '0) ? rd_cnt_q - 1'b1 : rd_cnt_q;
        aw_hold_d = ~in_rst & aw_valid_o & ~aw_ready_i;
        ar_hold_d = ~in_rst & ar_valid_o & ~ar_ready_i;
        underflow_d = (b_hs & ~aw_hs & wr_cnt_q == '0) | (r_done & ~ar_hs & rd_cnt_q == '0)
                    | (underflow_q & ~clr_i);
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        pending_d = pending_q | rst_req_i;
        to_set = 1'b0;
        case (state_q)
            IDLE: begin
                pending_d = 1'b0;
                timer_d = '0;
                if (rst_req_i | pending_q) state_d = FENCE;
            end
            FENCE: begin
                if (wr_cnt_q == '0 && rd_cnt_q == '0 && !aw_hold_q && !ar_hold_q) begin
                    state_d = RESET;
                    timer_d = '0;
                end else if (timer_q == CntWidth'(DrainTimeout - 1)) begin
                    state_d = RESET;
                    timer_d = '0;
                    to_set = 1'b1;
                end
            end
            RESET: if (timer_q == CntWidth'(RstCycles - 1)) state_d = RELEASE;
            default: state_d = IDLE;
        endcase
        timeout_d = to_set | (timeout_q & ~clr_i);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            timer_q <= '0;
            aw_hold_q <= 1'b0;
            ar_hold_q <= 1'b0;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            timer_q <= timer_d;
            aw_hold_q <= aw_hold_d;
            ar_hold_q <= ar_hold_d;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
            underflow_q <= underflow_d;
        end
    end
`ifdef SLV_RST_CTRL_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk_i) begin
        irq_q <= rst_i ? 1'b0 : state_q == RELEASE;
    end
    assign irq_o = irq_q;
`endif
endmodule

// File: tb/tb_slv_rst_ctrl.sv
// tb_slv_rst_ctrl: table-driven and directed checks for slv_rst_ctrl.
module tb_slv_rst_ctrl;
    logic clk_i = 1'b0;
    logic rst_i, rst_req_i, aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i;
    logic b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i, clr_i;
    logic aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o;
    logic slv_rst_o, busy_o, timeout_o, underflow_o;
`ifdef SLV_RST_CTRL_IRQ_EN
    logic irq_o;
`endif
    int checks = 0;
    int failures = 0;
    slv_rst_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .rst_req_i(rst_req_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .r_valid_i(r_valid_i), .r_ready_i(r_ready_i),
        .r_last_i(r_last_i), .slv_rst_o(slv_rst_o), .busy_o(busy_o), .timeout_o(timeout_o),
        .underflow_o(underflow_o), .clr_i(clr_i)
`ifdef SLV_RST_CTRL_IRQ_EN
        , .irq_o(irq_o)
`endif
    );
    always #5 clk_i = ~clk_i;
    // in: {rst, req, awv, awr, arv, arr, bv, br, rv, rr, rlast, clr}
    // exp: {aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o, slv_rst_o, busy_o, timeout_o, underflow_o}
    typedef struct {
        logic [11:0] in;
        logic [7:0]  exp;
    } vec_t;
    vec_t vt[21];
    string nm[8] = '{"underflow", "timeout", "busy", "slv_rst", "ar_ready", "ar_valid", "aw_ready", "aw_valid"};
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask
    task automatic zero_in();
        {rst_req_i, aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i} = '0;
        {b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i, clr_i} = '0;
    endtask
    task automatic do_reset();
        zero_in();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask
    task automatic wait_srst(input logic lvl, input int max, output int n);
        n = 0;
        while (slv_rst_o !== lvl && n < max) begin
            cyc();
            n++;
        end
    endtask
    initial begin
        int n;
        logic [7:0] act;
        vt[0]  = '{12'b000000000000, 8'b00000000};
        vt[1]  = '{12'b001100000000, 8'b11000000};
        vt[2]  = '{12'b001011000000, 8'b10110000};
        vt[3]  = '{12'b000000110000, 8'b00000000};
        vt[4]  = '{12'b000000110000, 8'b00000000};
        vt[5]  = '{12'b000000001110, 8'b00000001};
        vt[6]  = '{12'b000000001110, 8'b00000001};
        vt[7]  = '{12'b000000000001, 8'b00000001};
        vt[8]  = '{12'b000000000000, 8'b00000000};
        vt[9]  = '{12'b000000110001, 8'b00000000};
        vt[10] = '{12'b000000000000, 8'b00000001};
        vt[11] = '{12'b101100000000, 8'b11000001};
        vt[12] = '{12'b000000000000, 8'b00000000};
        vt[13] = '{12'b000010000000, 8'b00100000};
        vt[14] = '{12'b010010000000, 8'b00100000};
        vt[15] = '{12'b000010000000, 8'b00100100};
        vt[16] = '{12'b001111000000, 8'b00110100};
        vt[17] = '{12'b000011000000, 8'b00000100};
        vt[18] = '{12'b000000001110, 8'b00000100};
        vt[19] = '{12'b000000000000, 8'b00000100};
        vt[20] = '{12'b000000000000, 8'b00001100};
        do_reset();
        chk("reset_busy", busy_o, 0);
        chk("reset_slv_rst", slv_rst_o, 0);
        chk("reset_timeout", timeout_o, 0);
        chk("reset_underflow", underflow_o, 0);
        for (int i = 0; i < 21; i++) begin
            {rst_i, rst_req_i, aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
             b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i, clr_i} = vt[i].in;
            #1;
            act = {aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o, slv_rst_o, busy_o, timeout_o, underflow_o};
            for (int b = 0; b < 8; b++) chk($sformatf("vec%0d_%s", i, nm[b]), act[b], vt[i].exp[b]);
            cyc();
        end
        // Outstanding cap
        do_reset();
        aw_valid_i = 1'b1;
        aw_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("cap_accept%0d", i), aw_ready_o, 1);
            cyc();
        end
        #1 chk("cap_full_ready", aw_ready_o, 0);
        chk("cap_full_valid", aw_valid_o, 0);
        zero_in();
        b_valid_i = 1'b1;
        b_ready_i = 1'b1;
        cyc();
        zero_in();
        aw_valid_i = 1'b1;
        aw_ready_i = 1'b1;
        #1 chk("cap_after_b", aw_ready_o, 1);
        cyc();
        chk("cap_full_again", aw_ready_o, 0);
        // Simultaneous AW and B at count 3
        do_reset();
        aw_valid_i = 1'b1;
        aw_ready_i = 1'b1;
        repeat (3) cyc();
        b_valid_i = 1'b1;
        b_ready_i = 1'b1;
        cyc();
        b_valid_i = 1'b0;
        b_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("simul_accept%0d", i), aw_ready_o, 1);
            cyc();
        end
        chk("simul_cap", aw_ready_o, 0);
        chk("simul_no_underflow", underflow_o, 0);
        // Clean drain
        do_reset();
        aw_valid_i = 1'b1;
        aw_ready_i = 1'b1;
        cyc();
        cyc();
        zero_in();
        ar_valid_i = 1'b1;
        ar_ready_i = 1'b1;
        cyc();
        zero_in();
        rst_req_i = 1'b1;
        #1 chk("drain_idle_busy", busy_o, 0);
        cyc();
        rst_req_i = 1'b0;
        chk("drain_fence_busy", busy_o, 1);
        aw_valid_i = 1'b1;
        aw_ready_i = 1'b1;
        #1 chk("drain_fence_closed", aw_ready_o, 0);
        zero_in();
        b_valid_i = 1'b1;
        b_ready_i = 1'b1;
        cyc();
        cyc();
        zero_in();
        {r_valid_i, r_ready_i, r_last_i} = 3'b111;
        cyc();
        zero_in();
        chk("drain_still_fence", slv_rst_o, 0);
        cyc();
        chk("drain_reset_entry", slv_rst_o, 1);
        n = 0;
        while (slv_rst_o && n < 40) begin
            cyc();
            n++;
        end
        chk("drain_rst_len", n, 16);
        chk("drain_release_busy", busy_o, 1);
        cyc();
        chk("drain_idle", busy_o, 0);
        chk("drain_no_timeout", timeout_o, 0);
`ifdef SLV_RST_CTRL_IRQ_EN
        chk("drain_irq", irq_o, 1);
`endif
        // Drain timeout
        do_reset();
        aw_valid_i = 1'b1;
        aw_ready_i = 1'b1;
        cyc();
        zero_in();
        rst_req_i = 1'b1;
        cyc();
        rst_req_i = 1'b0;
        wait_srst(1'b1, 600, n);
        chk("timeout_cycles", n, 512);
        chk("timeout_set", timeout_o, 1);
        wait_srst(1'b0, 40, n);
        cyc();
        chk("timeout_sticky", timeout_o, 1);
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        chk("timeout_clr", timeout_o, 0);
        // Hold across the fence
        do_reset();
        aw_valid_i = 1'b1;
        rst_req_i = 1'b1;
        #1 chk("hold_idle_valid", aw_valid_o, 1);
        cyc();
        rst_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold_valid%0d", i), aw_valid_o, 1);
            chk($sformatf("hold_ready%0d", i), aw_ready_o, 0);
            cyc();
        end
        aw_ready_i = 1'b1;
        #1 chk("hold_handshake", aw_ready_o, 1);
        cyc();
        aw_ready_i = 1'b0;
        #1 chk("hold_closed_after", aw_valid_o, 0);
        zero_in();
        repeat (5) cyc();
        chk("hold_wait_b", slv_rst_o, 0);
        b_valid_i = 1'b1;
        b_ready_i = 1'b1;
        cyc();
        zero_in();
        wait_srst(1'b1, 5, n);
        chk("hold_drained", slv_rst_o, 1);
        // Pending request during RESET
        do_reset();
        rst_req_i = 1'b1;
        cyc();
        rst_req_i = 1'b0;
        wait_srst(1'b1, 5, n);
        chk("pend_first_reset", slv_rst_o, 1);
        rst_req_i = 1'b1;
        cyc();
        rst_req_i = 1'b0;
        wait_srst(1'b0, 40, n);
        chk("pend_release", busy_o, 1);
        cyc();
        aw_ready_i = 1'b1;
        #1 chk("pend_idle", busy_o, 0);
        chk("pend_gate_open", aw_ready_o, 1);
        aw_ready_i = 1'b0;
        cyc();
        chk("pend_refence", busy_o, 1);
        wait_srst(1'b1, 5, n);
        chk("pend_second_reset", slv_rst_o, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
